ball_motion: RTL and testbench

//   Ball position/direction engine for pong. Once per video frame it advances
//   the ball centre, reflects off the top/bottom walls and both paddles, and

---
 rtl/ball_motion.sv | 186 ++++++++++++++++++
 tb/tb_ball_motion.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball position/direction engine for pong.
// Moves the ball centre on each frame tick while in play, reflects off the
// top/bottom walls and both paddle faces, and flags a point on a miss.
module ball_motion #(
    parameter int DISP_COLS     = 640,
    parameter int DISP_ROWS     = 480,
    parameter int BALL_HEIGHT   = 8,
    parameter int BALL_WIDTH    = 6,
    parameter int STEP          = 2,
    parameter int PADDLE_HEIGHT = 48,
    parameter int L_PADDLE_FACE = 24,
    parameter int R_PADDLE_FACE = 615,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [11:0] l_paddle_row,
    input  logic [11:0] r_paddle_row,
    output logic [11:0] ball_center_row,
    output logic [11:0] ball_center_col,
    output logic [1:0]  ball_direction,
    output logic        ball_active,
    output logic        l_point,
    output logic        r_point
);

    // Direction codes: bit 0 set = moving down, bit 1 set = moving right.
    localparam logic [1:0] UP_LEFT    = 2'd0;
    localparam logic [1:0] DOWN_LEFT  = 2'd1;
    localparam logic [1:0] UP_RIGHT   = 2'd2;
    localparam logic [1:0] DOWN_RIGHT = 2'd3;

    localparam logic [11:0] HH        = 12'(BALL_HEIGHT / 2);
    localparam logic [11:0] HW        = 12'(BALL_WIDTH / 2);
    localparam logic [11:0] STP       = 12'(STEP);
    localparam logic [11:0] REACH     = 12'(PADDLE_HEIGHT / 2 + BALL_HEIGHT / 2);
    localparam logic [11:0] LFACE     = 12'(L_PADDLE_FACE);
    localparam logic [11:0] RFACE     = 12'(R_PADDLE_FACE);
    localparam logic [11:0] ROW_LAST  = 12'(DISP_ROWS - 1);
    localparam logic [11:0] COL_LAST  = 12'(DISP_COLS - 1);
    localparam logic [11:0] ROW_MID   = 12'(DISP_ROWS / 2);
    localparam logic [11:0] COL_MID   = 12'(DISP_COLS / 2);
    localparam int          CNT_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_t;

    state_t           state, state_nx;
    logic [11:0]      row_nx, col_nx;
    logic [1:0]       dir_nx;
    logic             toggle, toggle_nx;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic             l_point_nx, r_point_nx;

    // Paddle distances and the vertical update are independent of the
    // horizontal decision, so they are derived up front.
    logic [11:0] l_dist, r_dist;
    logic [11:0] vert_row;
    logic        vert_down;

    // Absolute row distance to each paddle, ordered so it never wraps.
    always_comb begin
        l_dist = (ball_center_row >= l_paddle_row) ? ball_center_row - l_paddle_row
                                                   : l_paddle_row - ball_center_row;
        r_dist = (ball_center_row >= r_paddle_row) ? ball_center_row - r_paddle_row
                                                   : r_paddle_row - ball_center_row;
    end

    // Vertical step with wall reflection; comparisons are arranged to avoid underflow.
    always_comb begin
        vert_row  = ball_center_row;
        vert_down = ball_direction[0];
        if (!ball_direction[0]) begin
            if (ball_center_row <= STP + HH) begin
                vert_row  = HH;
                vert_down = 1'b1;
            end else begin
                vert_row  = ball_center_row - STP;
            end
        end else begin
            if (ball_center_row + HH + STP >= ROW_LAST) begin
                vert_row  = ROW_LAST - HH;
                vert_down = 1'b0;
            end else begin
                vert_row  = ball_center_row + STP;
            end
        end
    end

    // Next-state and next-output logic for the serve / play / hold sequence.
    always_comb begin
        state_nx    = state;
        row_nx      = ball_center_row;
        col_nx      = ball_center_col;
        dir_nx      = ball_direction;
        toggle_nx   = toggle;
        hold_cnt_nx = hold_cnt;
        l_point_nx  = 1'b0;
        r_point_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (serve) begin
                    state_nx  = MOVE;
                    dir_nx    = toggle ? UP_LEFT : DOWN_RIGHT;
                    toggle_nx = ~toggle;
                end
            end
            MOVE: begin
                if (frame_tick) begin
                    row_nx    = vert_row;
                    dir_nx[0] = vert_down;
                    if (!ball_direction[1]) begin
                        if (ball_center_col > LFACE + HW &&
                            ball_center_col <= LFACE + HW + STP &&
                            l_dist <= REACH) begin
                            col_nx    = LFACE + 12'd1 + HW;
                            dir_nx[1] = 1'b1;
                        end else if (ball_center_col <= STP + HW) begin
                            col_nx      = HW;
                            r_point_nx  = 1'b1;
                            state_nx    = SCORED;
                            hold_cnt_nx = '0;
                        end else begin
                            col_nx = ball_center_col - STP;
                        end
                    end else begin
                        if (ball_center_col + HW < RFACE &&
                            ball_center_col + HW + STP >= RFACE &&
                            r_dist <= REACH) begin
                            col_nx    = RFACE - 12'd1 - HW;
                            dir_nx[1] = 1'b0;
                        end else if (ball_center_col + HW + STP >= COL_LAST) begin
                            col_nx      = COL_LAST - HW;
                            l_point_nx  = 1'b1;
                            state_nx    = SCORED;
                            hold_cnt_nx = '0;
                        end else begin
                            col_nx = ball_center_col + STP;
                        end
                    end
                end
            end
            SCORED: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nx    = IDLE;
                        row_nx      = ROW_MID;
                        col_nx      = COL_MID;
                        hold_cnt_nx = '0;
                    end else begin
                        hold_cnt_nx = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers, with synchronous reset back to a centred idle ball.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ball_center_row <= ROW_MID;
            ball_center_col <= COL_MID;
            ball_direction  <= DOWN_RIGHT;
            toggle          <= 1'b0;
            hold_cnt        <= '0;
            l_point         <= 1'b0;
            r_point         <= 1'b0;
        end else begin
            state           <= state_nx;
            ball_center_row <= row_nx;
            ball_center_col <= col_nx;
            ball_direction  <= dir_nx;
            toggle          <= toggle_nx;
            hold_cnt        <= hold_cnt_nx;
            l_point         <= l_point_nx;
            r_point         <= r_point_nx;
        end
    end

    assign ball_active = (state == MOVE);

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: random serves, ticks, paddle positions and
// occasional resets drive both the DUT and a plain-integer model of the game.
module tb_ball_motion;

    localparam int COLS = 640, ROWS = 480, HH = 4, HW = 3, STEP = 2;
    localparam int REACH = 24 + 4, LF = 24, RF = 615, HOLD = 60;
    localparam int NCYC = 40000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        serve = 1'b0;
    logic [11:0] l_paddle_row = 12'd240;
    logic [11:0] r_paddle_row = 12'd240;
    logic [11:0] ball_center_row, ball_center_col;
    logic [1:0]  ball_direction;
    logic        ball_active, l_point, r_point;

    ball_motion dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
        .l_paddle_row(l_paddle_row), .r_paddle_row(r_paddle_row),
        .ball_center_row(ball_center_row), .ball_center_col(ball_center_col),
        .ball_direction(ball_direction), .ball_active(ball_active),
        .l_point(l_point), .r_point(r_point)
    );

    always #5 clk = ~clk;

    // Expected output vector: {row, col, dir, active, l_point, r_point}
    logic [28:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_lpt = 0, n_rpt = 0, n_hits = 0;

    // Model state: 0 idle, 1 in play, 2 holding after a point
    int m_state, m_row, m_col, m_dx, m_dy, m_tog, m_cnt, m_lp, m_rp;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input bit rst, input bit tick, input bit srv,
                              input int lpr, input int rpr);
        int r, c;
        m_lp = 0;
        m_rp = 0;
        if (rst) begin
            m_state = 0; m_row = ROWS / 2; m_col = COLS / 2;
            m_dx = 1; m_dy = 1; m_tog = 0; m_cnt = 0;
            return;
        end
        r = m_row;
        c = m_col;
        case (m_state)
            0: if (srv) begin
                m_state = 1;
                m_dx = m_tog ? -1 : 1;
                m_dy = m_tog ? -1 : 1;
                m_tog = 1 - m_tog;
            end
            1: if (tick) begin
                if (m_dy < 0) begin
                    if (r - HH <= STEP) begin m_row = HH; m_dy = 1; end
                    else m_row = r - STEP;
                end else begin
                    if (r + HH + STEP >= ROWS - 1) begin m_row = ROWS - 1 - HH; m_dy = -1; end
                    else m_row = r + STEP;
                end
                if (m_dx < 0) begin
                    if (c - HW > LF && c - HW - STEP <= LF && iabs(r - lpr) <= REACH) begin
                        m_col = LF + 1 + HW; m_dx = 1; n_hits++;
                    end else if (c - HW <= STEP) begin
                        m_col = HW; m_rp = 1; m_state = 2; m_cnt = 0;
                    end else m_col = c - STEP;
                end else begin
                    if (c + HW < RF && c + HW + STEP >= RF && iabs(r - rpr) <= REACH) begin
                        m_col = RF - 1 - HW; m_dx = -1; n_hits++;
                    end else if (c + HW + STEP >= COLS - 1) begin
                        m_col = COLS - 1 - HW; m_lp = 1; m_state = 2; m_cnt = 0;
                    end else m_col = c + STEP;
                end
            end
            default: if (tick) begin
                m_cnt++;
                if (m_cnt == HOLD) begin
                    m_state = 0; m_row = ROWS / 2; m_col = COLS / 2; m_cnt = 0;
                end
            end
        endcase
    endtask

    function automatic logic [28:0] model_vec();
        logic [1:0] d;
        d = {(m_dx > 0) ? 1'b1 : 1'b0, (m_dy > 0) ? 1'b1 : 1'b0};
        return {12'(m_row), 12'(m_col), d, (m_state == 1) ? 1'b1 : 1'b0,
                m_lp[0], m_rp[0]};
    endfunction

    function automatic logic [11:0] paddle_near(input int row);
        int p;
        if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, ROWS - 1));
        p = row + $urandom_range(0, 120) - 60;
        if (p < 0) p = 0;
        if (p > ROWS - 1) p = ROWS - 1;
        return 12'(p);
    endfunction

    // Monitor: one registered output per clock, compared just after the edge.
    initial begin
        logic [28:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {ball_center_row, ball_center_col, ball_direction,
                         ball_active, l_point, r_point};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cyc %0d outputs: got row=%0d col=%0d dir=%0d act=%b lp=%b rp=%b, want row=%0d col=%0d dir=%0d act=%b lp=%b rp=%b",
                             cyc, act_v[28:17], act_v[16:5], act_v[4:3], act_v[2], act_v[1], act_v[0],
                             exp_v[28:17], exp_v[16:5], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
                end
                if (exp_v[1]) n_lpt++;
                if (exp_v[0]) n_rpt++;
            end
        end
    end

    // Stimulus: inputs change on the falling edge; the model predicts the next registered outputs.
    initial begin
        bit rst_b, tick_b, srv_b;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            cyc = i;
            if (i < 2) begin
                rst_b = 1; tick_b = 0; srv_b = 0;
            end else if (i < 8) begin
                rst_b = 0; tick_b = (i % 2 == 0); srv_b = 0;
            end else begin
                rst_b  = ($urandom_range(0, 2999) == 0);
                tick_b = ($urandom_range(0, 1) == 0);
                srv_b  = ($urandom_range(0, 3) == 0);
            end
            reset        = rst_b;
            frame_tick   = tick_b;
            serve        = srv_b;
            l_paddle_row = paddle_near(m_row);
            r_paddle_row = paddle_near(m_row);
            model_step(rst_b, tick_b, srv_b, int'(l_paddle_row), int'(r_paddle_row));
            exp_q.push_back(model_vec());
        end
        @(negedge clk);
        reset = 0; frame_tick = 0; serve = 0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (n_hits == 0 || n_lpt == 0 || n_rpt == 0) begin
            n_bad++;
            $display("FAIL coverage: hits=%0d lpoints=%0d rpoints=%0d, need each > 0",
                     n_hits, n_lpt, n_rpt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
